// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core port (0) and the IO/debug port (1)
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [DATA_W-1:0] o_m0_rdata,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_mem_en,
  output logic              o_mem_wren,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dmem_arbiter: RD_LAT must be in 1..4");
  end
  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_port;
  logic        r_we;
  logic [1:0]  r_cnt;
  logic        w_take;
  logic        w_win;
  logic        w_cap;
  // arbitration (requests only considered in IDLE) and next-state selection
  always_comb begin
    w_take = (r_state == IDLE) && (i_m0_req || i_m1_req);
    w_win  = (i_m0_req && i_m1_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : i_m1_req;
    w_cap  = (r_state == WAIT) && (r_cnt == 2'd0);
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_take ? ISSUE : IDLE;
      ISSUE:   w_next = r_we ? IDLE : WAIT;
      WAIT:    w_next = w_cap ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // command latch, registered strobes/grants and read-return routing to the winning port
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last      <= 1'b1;
      r_port      <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= 2'd0;
      o_mem_en    <= 1'b0;
      o_mem_wren  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_m0_gnt    <= 1'b0;
      o_m1_gnt    <= 1'b0;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_mem_en    <= w_take;
      o_mem_wren  <= w_take && (w_win ? i_m1_we : i_m0_we);
      o_m0_gnt    <= w_take && !w_win;
      o_m1_gnt    <= w_take && w_win;
      o_m0_rvalid <= w_cap && !r_port;
      o_m1_rvalid <= w_cap && r_port;
      o_busy      <= w_next != IDLE;
      r_cnt       <= (r_state == ISSUE) ? CNT_LOAD : (r_state == WAIT) ? r_cnt - 2'd1 : r_cnt;
      if (w_take) begin
        r_we        <= w_win ? i_m1_we : i_m0_we;
        r_port      <= w_win;
        r_last      <= w_win;
        o_mem_addr  <= w_win ? i_m1_addr : i_m0_addr;
        o_mem_wdata <= w_win ? i_m1_wdata : i_m0_wdata;
      end
      if (w_cap && !r_port) o_m0_rdata <= i_mem_rdata;
      if (w_cap && r_port)  o_m1_rdata <= i_mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiter configurations checked cycle by cycle against a transaction-level model
module tb_dmem_arbiter;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} cmd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  // per requester index i = 2*dut + port
  logic        rq [6];
  logic        we [6];
  logic [31:0] ad [6];
  logic [31:0] wd [6];
  logic        gnt [6];
  logic        rv [6];
  logic [31:0] rd [6];
  logic        en [3];
  logic        wr [3];
  logic        busy [3];
  logic [31:0] maddr [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  cmd_t cq [6][8];
  int head [6];
  int tail [6];
  int pres_cyc [6];
  // model state: one outstanding transaction per DUT, described by its start cycle
  logic mact [3];
  logic mwe [3];
  logic mp [3];
  logic mlast [3];
  int   mt0 [3];
  int   mdur [3];
  logic [31:0] ma [3];
  logic egnt [6];
  logic erv [6];
  logic een [3];
  logic ewr [3];
  logic ebusy [3];
  logic [31:0] erd [6];
  logic [31:0] ema [3];
  logic [31:0] emw [3];
  // grant / rvalid logs for directed checks
  int gcount [3];
  int glog_port [3][16];
  int glog_cyc [3][16];
  logic [31:0] glog_addr [3][16];
  logic [31:0] glog_wd [3][16];
  logic glog_wr [3][16];
  int rv_cnt [6];
  int rv_cyc [6];
  logic busy_hist [3][64];
  int exp_rr [4] = '{0, 1, 0, 1};
  int exp_fx [4] = '{0, 0, 0, 1};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(g == 2 ? 4 : 1), .FIXED_PRIO(g == 1 ? 1 : 0)
    ) u_dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_m0_req(rq[2*g]), .i_m0_we(we[2*g]), .i_m0_addr(ad[2*g]), .i_m0_wdata(wd[2*g]),
      .o_m0_gnt(gnt[2*g]), .o_m0_rvalid(rv[2*g]), .o_m0_rdata(rd[2*g]),
      .i_m1_req(rq[2*g+1]), .i_m1_we(we[2*g+1]), .i_m1_addr(ad[2*g+1]), .i_m1_wdata(wd[2*g+1]),
      .o_m1_gnt(gnt[2*g+1]), .o_m1_rvalid(rv[2*g+1]), .o_m1_rdata(rd[2*g+1]),
      .o_mem_en(en[g]), .o_mem_wren(wr[g]), .o_mem_addr(maddr[g]), .o_mem_wdata(mwd[g]),
      .i_mem_rdata(mrd[g]), .o_busy(busy[g])
    );
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
  endfunction

  task automatic chkb(input string nm, input logic a, input logic e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b want %b (cycle %0d)", nm, a, e, cyc);
  endtask

  task automatic chkw(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
  endtask

  task automatic push(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    cq[i][tail[i]].w = w;
    cq[i][tail[i]].a = a;
    cq[i][tail[i]].d = d;
    tail[i]++;
  endtask

  task automatic drain(input int k);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (head[2*k] == tail[2*k] && head[2*k+1] == tail[2*k+1] && !rq[2*k] && !rq[2*k+1] && !mact[k]) break;
    end
    chkb($sformatf("drain_d%0d", k), i < 400, 1'b1);
  endtask

  // requesters: hold req until gnt, then present the next queued command (or drop)
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rq[i] && gnt[i]) begin
        head[i]++;
        rq[i] = 1'b0;
      end
      if (!rq[i] && head[i] < tail[i]) begin
        rq[i] = 1'b1;
        we[i] = cq[i][head[i]].w;
        ad[i] = cq[i][head[i]].a;
        wd[i] = cq[i][head[i]].d;
        pres_cyc[i] = cyc;
      end
    end
  end

  // model: at each edge decide what the outputs must be in the next cycle
  always @(posedge clk) begin
    int n, lat, i0, wi;
    logic w;
    n = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      lat = (k == 2) ? 4 : 1;
      i0 = 2 * k;
      egnt[i0] = 1'b0; egnt[i0+1] = 1'b0; erv[i0] = 1'b0; erv[i0+1] = 1'b0;
      een[k] = 1'b0; ewr[k] = 1'b0; ebusy[k] = 1'b0;
      if (!rst_n) begin
        mact[k] = 1'b0; mlast[k] = 1'b1; ema[k] = '0; emw[k] = '0;
        erd[i0] = '0; erd[i0+1] = '0;
      end else begin
        if (mact[k] && cyc >= mt0[k] + mdur[k]) mact[k] = 1'b0;
        if (!mact[k] && (rq[i0] || rq[i0+1])) begin
          if (rq[i0] && rq[i0+1]) w = (k == 1) ? 1'b0 : (mlast[k] ? 1'b0 : 1'b1);
          else w = rq[i0+1];
          wi = w ? i0 + 1 : i0;
          mact[k] = 1'b1; mt0[k] = cyc; mp[k] = w; mlast[k] = w;
          mwe[k] = we[wi]; ma[k] = ad[wi];
          ema[k] = ad[wi]; emw[k] = wd[wi];
          mdur[k] = we[wi] ? 2 : lat + 3;
        end
        if (mact[k]) begin
          wi = mp[k] ? i0 + 1 : i0;
          if (n == mt0[k] + 1) begin
            egnt[wi] = 1'b1; een[k] = 1'b1; ewr[k] = mwe[k];
          end
          if (!mwe[k] && n == mt0[k] + 2 + lat) begin
            erv[wi] = 1'b1; erd[wi] = data_of(ma[k]);
          end
          ebusy[k] = (n >= mt0[k] + 1) && (n < mt0[k] + mdur[k]);
        end
      end
    end
    cyc++;
  end

  // compare every output every cycle; drive memory read data (noise except in the sample cycle)
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 3; k++) begin
      int i0, lat;
      i0 = 2 * k;
      lat = (k == 2) ? 4 : 1;
      chkb($sformatf("d%0d_gnt0", k), gnt[i0], egnt[i0]);
      chkb($sformatf("d%0d_gnt1", k), gnt[i0+1], egnt[i0+1]);
      chkb($sformatf("d%0d_rvalid0", k), rv[i0], erv[i0]);
      chkb($sformatf("d%0d_rvalid1", k), rv[i0+1], erv[i0+1]);
      chkw($sformatf("d%0d_rdata0", k), rd[i0], erd[i0]);
      chkw($sformatf("d%0d_rdata1", k), rd[i0+1], erd[i0+1]);
      chkb($sformatf("d%0d_mem_en", k), en[k], een[k]);
      chkb($sformatf("d%0d_mem_wren", k), wr[k], ewr[k]);
      chkw($sformatf("d%0d_mem_addr", k), maddr[k], ema[k]);
      chkw($sformatf("d%0d_mem_wdata", k), mwd[k], emw[k]);
      chkb($sformatf("d%0d_busy", k), busy[k], ebusy[k]);
      busy_hist[k][cyc % 64] = busy[k];
      if ((gnt[i0] || gnt[i0+1]) && gcount[k] < 16) begin
        glog_port[k][gcount[k]] = gnt[i0+1] ? 1 : 0;
        glog_cyc[k][gcount[k]] = cyc;
        glog_addr[k][gcount[k]] = maddr[k];
        glog_wd[k][gcount[k]] = mwd[k];
        glog_wr[k][gcount[k]] = wr[k];
        gcount[k]++;
      end
      for (int p = 0; p < 2; p++) if (rv[i0+p]) begin
        rv_cnt[i0+p]++;
        rv_cyc[i0+p] = cyc;
      end
      mrd[k] = (mact[k] && !mwe[k] && cyc == mt0[k] + 1 + lat) ? data_of(ma[k]) : $urandom;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, g, i, rvc;
    for (int j = 0; j < 6; j++) begin
      rq[j] = 1'b0; we[j] = 1'b0; ad[j] = '0; wd[j] = '0;
    end
    for (int k = 0; k < 3; k++) mrd[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chkb("reset_busy", busy[0], 1'b0);
    chkw("reset_rdata0", rd[0], 32'h0);
    // A: lone port-0 read on DUT0
    @(posedge clk); #2;
    push(0, 1'b0, 32'h10, 32'h0);
    drain(0);
    t = pres_cyc[0];
    chkw("A_gnt_cycle", glog_cyc[0][0], t + 1);
    chkw("A_gnt_port", glog_port[0][0], 0);
    chkw("A_mem_addr", glog_addr[0][0], 32'h10);
    chkb("A_mem_wren", glog_wr[0][0], 1'b0);
    chkw("A_rvalid_cycle", rv_cyc[0], t + 3);
    chkw("A_rdata", rd[0], 32'hDEADBEEF);
    chkw("A_no_rvalid1", rv_cnt[1], 0);
    // B: lone port-1 write on DUT0
    @(posedge clk); #2;
    push(1, 1'b1, 32'h20, 32'h12345678);
    drain(0);
    t = pres_cyc[1];
    chkw("B_gnt_cycle", glog_cyc[0][1], t + 1);
    chkw("B_gnt_port", glog_port[0][1], 1);
    chkb("B_mem_wren", glog_wr[0][1], 1'b1);
    chkw("B_mem_addr", glog_addr[0][1], 32'h20);
    chkw("B_mem_wdata", glog_wd[0][1], 32'h12345678);
    chkb("B_busy_t1", busy_hist[0][(t + 1) % 64], 1'b1);
    chkb("B_busy_t2", busy_hist[0][(t + 2) % 64], 1'b0);
    chkw("B_no_rvalid1", rv_cnt[1], 0);
    // C: round-robin conflict on DUT0
    @(posedge clk); #2;
    g = gcount[0];
    push(0, 1'b0, 32'h100, 32'h0);
    push(0, 1'b0, 32'h104, 32'h0);
    push(1, 1'b0, 32'h200, 32'h0);
    push(1, 1'b0, 32'h204, 32'h0);
    drain(0);
    for (int j = 0; j < 4; j++) chkw($sformatf("C_order%0d", j), glog_port[0][g+j], exp_rr[j]);
    chkw("C_rdata0", rd[0], 32'hC0DE0104);
    chkw("C_rdata1", rd[1], 32'hC0DE0204);
    // D: fixed priority on DUT1
    @(posedge clk); #2;
    push(2, 1'b0, 32'h300, 32'h0);
    push(2, 1'b0, 32'h304, 32'h0);
    push(2, 1'b0, 32'h308, 32'h0);
    push(3, 1'b0, 32'h400, 32'h0);
    drain(1);
    for (int j = 0; j < 4; j++) chkw($sformatf("D_order%0d", j), glog_port[1][j], exp_fx[j]);
    chkw("D_rdata0", rd[2], 32'hC0DE0308);
    chkw("D_rdata1", rd[3], 32'hC0DE0400);
    // E: RD_LAT=4 read on DUT2
    @(posedge clk); #2;
    push(4, 1'b0, 32'h40, 32'h0);
    drain(2);
    chkw("E_rvalid_latency", rv_cyc[4] - pres_cyc[4], 6);
    chkw("E_rdata", rd[4], 32'hC0DE0040);
    // F: reset while DUT2 is waiting for read data
    @(posedge clk); #2;
    push(4, 1'b0, 32'h44, 32'h0);
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (head[4] == tail[4] && cyc == pres_cyc[4] + 3) break;
    end
    chkb("F_reached_wait", i < 30, 1'b1);
    chkb("F_busy_before", busy[2], 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("F_busy_now", busy[2], 1'b0);
    chkw("F_rdata_now", rd[4], 32'h0);
    chkw("F_addr_now", maddr[2], 32'h0);
    chkw("F_d0_rdata_now", rd[0], 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rvc = rv_cnt[4];
    repeat (10) @(negedge clk);
    chkw("F_no_rvalid", rv_cnt[4], rvc);
    @(posedge clk); #2;
    g = gcount[2];
    push(4, 1'b0, 32'h50, 32'h0);
    push(5, 1'b0, 32'h60, 32'h0);
    drain(2);
    chkw("F_first_conflict", glog_port[2][g], 0);
    chkw("F_second_conflict", glog_port[2][g+1], 1);
    chkw("F_rdata1", rd[5], 32'hC0DE0060);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
